// File: rtl/fifo_pkg.sv
// Shared state encoding and parameter defaults for the FIFO self-test sequencer.
package fifo_pkg;

    localparam int DEF_DATA_W    = 8;
    localparam int DEF_MAX_WORDS = 256;
    localparam int DEF_SETTLE    = 4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FILL,
        ST_SETTLE_W,
        ST_DRAIN,
        ST_DONE
    } state_t;

    function automatic logic is_busy(input state_t s);
        return (s != ST_IDLE) && (s != ST_DONE);
    endfunction

endpackage

// File: rtl/fifo_chk.sv
// Read-back checker: one-cycle valid pipe behind rdreq, expected-value counter,
// read count and saturating mismatch count.
module fifo_chk
    import fifo_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              abort,
    input  logic              rdreq,
    input  logic [DATA_W-1:0] q,
    output logic [DATA_W:0]   rd_cnt,
    output logic [DATA_W:0]   err_cnt,
    output logic              pend
);

    logic              r_vld;
    logic [DATA_W-1:0] r_exp;
    logic [DATA_W:0]   r_rd_cnt;
    logic [DATA_W:0]   r_err_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_vld     <= 1'b0;
            r_exp     <= '0;
            r_rd_cnt  <= '0;
            r_err_cnt <= '0;
        end else if (abort) begin
            // the word in flight is dropped; counts stay as they are
            r_vld <= 1'b0;
        end else if (clr) begin
            r_vld     <= 1'b0;
            r_exp     <= '0;
            r_rd_cnt  <= '0;
            r_err_cnt <= '0;
        end else begin
            r_vld <= rdreq;
            if (r_vld) begin
                r_exp    <= r_exp + 1'b1;
                r_rd_cnt <= r_rd_cnt + 1'b1;
                if ((q != r_exp) && (r_err_cnt != '1))
                    r_err_cnt <= r_err_cnt + 1'b1;
            end
        end
    end

    assign rd_cnt  = r_rd_cnt;
    assign err_cnt = r_err_cnt;
    assign pend    = r_vld;

endmodule

// File: rtl/fifo_test_seq.sv
// FIFO self-test sequencer: fills the FIFO with an incrementing pattern, waits
// for the flags to settle, drains and checks it, then reports pass or fail.
module fifo_test_seq
    import fifo_pkg::*;
#(
    parameter int DATA_W    = DEF_DATA_W,
    parameter int MAX_WORDS = DEF_MAX_WORDS,
    parameter int SETTLE    = DEF_SETTLE
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic              wrfull,
    input  logic              rdempty,
    input  logic [DATA_W-1:0] q,
    output logic [DATA_W-1:0] data,
    output logic              wrreq,
    output logic              rdreq,
    output logic              busy,
    output logic              pass,
    output logic              fail,
    output logic [DATA_W:0]   wr_cnt,
    output logic [DATA_W:0]   rd_cnt,
    output logic [DATA_W:0]   err_cnt
);

    localparam int              SW          = (SETTLE < 2) ? 1 : $clog2(SETTLE);
    localparam logic [SW-1:0]   SETTLE_LAST = SW'(SETTLE - 1);
    localparam logic [DATA_W:0] MAX_CNT     = (DATA_W + 1)'(MAX_WORDS);

    state_t            r_state;
    logic [DATA_W-1:0] r_data;
    logic [DATA_W:0]   r_wr_cnt;
    logic [SW-1:0]     r_settle;
    logic              r_pass;
    logic              r_fail;

    logic              w_go;
    logic              w_wrreq;
    logic              w_rdreq;
    logic              w_clr;
    logic              w_pend;
    logic [DATA_W:0]   w_rd_cnt;
    logic [DATA_W:0]   w_err_cnt;

    // reset and abort both suppress FIFO requests in the cycle they are seen
    assign w_go    = !rst && !abort;
    assign w_wrreq = w_go && (r_state == ST_FILL) && !wrfull && (r_wr_cnt < MAX_CNT);
    assign w_rdreq = w_go && (r_state == ST_DRAIN) && !rdempty;
    assign w_clr   = w_go && start && ((r_state == ST_IDLE) || (r_state == ST_DONE));

    fifo_chk #(.DATA_W(DATA_W)) u_chk (
        .clk     (clk),
        .rst     (rst),
        .clr     (w_clr),
        .abort   (abort),
        .rdreq   (w_rdreq),
        .q       (q),
        .rd_cnt  (w_rd_cnt),
        .err_cnt (w_err_cnt),
        .pend    (w_pend)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= ST_IDLE;
            r_data   <= '0;
            r_wr_cnt <= '0;
            r_settle <= '0;
            r_pass   <= 1'b0;
            r_fail   <= 1'b0;
        end else if (abort) begin
            r_state  <= ST_IDLE;
            r_settle <= '0;
            r_pass   <= 1'b0;
            r_fail   <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        r_state  <= ST_FILL;
                        r_data   <= '0;
                        r_wr_cnt <= '0;
                        r_pass   <= 1'b0;
                        r_fail   <= 1'b0;
                    end
                end
                ST_FILL: begin
                    if (w_wrreq) begin
                        r_data   <= r_data + 1'b1;
                        r_wr_cnt <= r_wr_cnt + 1'b1;
                    end else if (wrfull || (r_wr_cnt == MAX_CNT)) begin
                        r_state  <= ST_SETTLE_W;
                        r_settle <= '0;
                    end
                end
                ST_SETTLE_W: begin
                    if (r_settle == SETTLE_LAST)
                        r_state <= ST_DRAIN;
                    else
                        r_settle <= r_settle + 1'b1;
                end
                ST_DRAIN: begin
                    // wait for the last read's compare before judging the run
                    if (rdempty && !w_pend) begin
                        r_state <= ST_DONE;
                        r_pass  <= (w_err_cnt == '0) && (w_rd_cnt == r_wr_cnt);
                        r_fail  <= !((w_err_cnt == '0) && (w_rd_cnt == r_wr_cnt));
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign data    = r_data;
    assign wrreq   = w_wrreq;
    assign rdreq   = w_rdreq;
    assign busy    = is_busy(r_state);
    assign pass    = r_pass;
    assign fail    = r_fail;
    assign wr_cnt  = r_wr_cnt;
    assign rd_cnt  = w_rd_cnt;
    assign err_cnt = w_err_cnt;

endmodule
